// File: rtl/button_conditioner.sv
// button_conditioner: input front end for the clock's five user controls.
// Each raw input passes through a 2-flop synchroniser and a counter-based
// debouncer. The set switch is presented as a debounced level; the four
// direction buttons produce a one-cycle pulse per accepted press.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_btn_set    raw set switch (asynchronous)
//   i_btn_up     raw up button (asynchronous)
//   i_btn_down   raw down button (asynchronous)
//   i_btn_left   raw left button (asynchronous)
//   i_btn_right  raw right button (asynchronous)
//   o_set        debounced set level
//   o_up/o_down/o_left/o_right  one-cycle press pulses
//
// Optional feature: define BTN_REPEAT_EN to make o_up/o_down auto-repeat
// while held (first repeat after REPEAT_DELAY, then every REPEAT_PERIOD).
module button_conditioner #(
  parameter int unsigned DB_COUNT      = 1000000,
  parameter int unsigned DB_CNT_W      = 20,
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_set,
  input  logic i_btn_up,
  input  logic i_btn_down,
  input  logic i_btn_left,
  input  logic i_btn_right,
  output logic o_set,
  output logic o_up,
  output logic o_down,
  output logic o_left,
  output logic o_right
);

  localparam int unsigned N_CH     = 5;
  localparam int unsigned CH_SET   = 0;
  localparam int unsigned CH_UP    = 1;
  localparam int unsigned CH_DOWN  = 2;
  localparam int unsigned CH_LEFT  = 3;
  localparam int unsigned CH_RIGHT = 4;

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_COUNT - 1);

`ifdef BTN_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
`endif

  logic [N_CH-1:0] raw_c;
  logic [N_CH-1:0] in_c;
  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] db;
  logic [N_CH-1:1] db_prev;
  logic [N_CH-1:1] rise_c;
  logic [N_CH-1:1] pulse;

  assign raw_c = {i_btn_right, i_btn_left, i_btn_down, i_btn_up, i_btn_set};
  assign in_c  = ACTIVE_LOW ? ~raw_c : raw_c;

  // Two-flop synchroniser for all channels
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_c;
      s2 <= s1;
    end
  end

  // Debouncer: db follows s2 only after DB_COUNT consecutive differing cycles
  for (genvar g = 0; g < N_CH; g++) begin : g_db
    logic [DB_CNT_W-1:0] cnt;
    logic                db_q;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        cnt  <= '0;
        db_q <= 1'b0;
      end else if (s2[g] == db_q) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        db_q <= s2[g];
        cnt  <= '0;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end

    assign db[g] = db_q;
  end

  // Previous debounced level for rising-edge detection on pulse channels
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      db_prev <= '0;
    end else begin
      db_prev <= db[N_CH-1:1];
    end
  end

  assign rise_c = db[N_CH-1:1] & ~db_prev;

  // Pulse generation per direction channel
  for (genvar g = 1; g < N_CH; g++) begin : g_pulse
    logic pulse_q;

`ifdef BTN_REPEAT_EN
    if (g == CH_UP || g == CH_DOWN) begin : g_rep
      logic [REP_W-1:0] rep_cnt;
      logic             rep_first;

      // Repeat counter restarts on the initial pulse and after every repeat
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          pulse_q   <= 1'b0;
          rep_cnt   <= '0;
          rep_first <= 1'b1;
        end else begin
          pulse_q <= 1'b0;
          if (!db[g]) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
          end else if (rise_c[g]) begin
            pulse_q   <= 1'b1;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
          end else if (rep_cnt == (rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
            pulse_q   <= 1'b1;
            rep_cnt   <= '0;
            rep_first <= 1'b0;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
          end
        end
      end
    end else begin : g_once
      always_ff @(posedge i_clk) begin
        if (i_rst) pulse_q <= 1'b0;
        else       pulse_q <= rise_c[g];
      end
    end
`else
    always_ff @(posedge i_clk) begin
      if (i_rst) pulse_q <= 1'b0;
      else       pulse_q <= rise_c[g];
    end
`endif

    assign pulse[g] = pulse_q;
  end

  assign o_set   = db[CH_SET];
  assign o_up    = pulse[CH_UP];
  assign o_down  = pulse[CH_DOWN];
  assign o_left  = pulse[CH_LEFT];
  assign o_right = pulse[CH_RIGHT];

endmodule
